// File: rtl/rr_event_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_event_count_arbiter
// Description : Round-robin arbiter sharing one modulo-TERM event counter
//               among NREQ requesters. The granted requester drives
//               increment pulses. When its count reaches TERM the block
//               emits a one-cycle done and releases the counter to the
//               next requester.
//               All outputs are decoded from registered state (Moore).
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous, active-low reset
//               req   - per-requester request (hold until done, drop = abort)
//               inc   - per-requester increment pulse (owner's only honoured)
//               gnt   - one-hot grant, zero when idle
//               owner - index of granted requester, zero when idle
//               cnt   - current count of the owner's session
//               busy  - high while a session is granted or completing
//               done  - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rr_event_count_arbiter #(
    parameter int NREQ  = 4,
    parameter int TERM  = 4,
    parameter int CNT_W = 3,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   inc,
    output logic [NREQ-1:0]   gnt,
    output logic [ID_W-1:0]   owner,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [ID_W:0]    c_NREQ    = (ID_W+1)'(NREQ);
    localparam logic [CNT_W-1:0] c_TERM    = CNT_W'(TERM);
    localparam logic [NREQ-1:0]  c_GNT_LSB = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  w_owner_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ID_W-1:0]  w_winner;
    logic             w_found;
    logic [ID_W:0]    w_idx;
    logic [ID_W:0]    w_succ_wide;
    logic [ID_W-1:0]  w_owner_succ;

    // Rotating search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && req[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    // Next pointer after a session ends: the requester just past the owner.
    always_comb begin
        w_succ_wide  = {1'b0, r_owner} + (ID_W+1)'(1);
        w_owner_succ = (w_succ_wide == c_NREQ) ? '0 : w_succ_wide[ID_W-1:0];
    end

    // TERM never exceeds the count range, so this add cannot wrap.
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                // Dropping the request wins over a simultaneous increment.
                if (!req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_owner_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_succ;
                end else if (inc[r_owner]) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_TERM) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = '0;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = w_owner_succ;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Owner and count registers are already zero while idle.
    assign busy  = (r_state == S_GRANT) || (r_state == S_DONE);
    assign done  = (r_state == S_DONE);
    assign gnt   = busy ? (c_GNT_LSB << r_owner) : '0;
    assign owner = r_owner;
    assign cnt   = r_cnt;

endmodule
`default_nettype wire
